uart_tx_arb: RTL
================

UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameters SHALL be: NREQ, default 4, number of requesters; DBIT, default 8, data width; LENW, default 4, burst-length field width.
REQ-002 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 reset_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 req  input  NREQ  per-requester burst request, level.
REQ-005 len  input  NREQ*LENW  per-requester burst length in bytes, slice i at [i*LENW +: LENW].
REQ-006 din  input  NREQ*DBIT  per-requester current data byte, slice i at [i*DBIT +: DBIT].
REQ-007 ack  output  NREQ  one-cycle pulse: byte of requester i accepted; requester SHALL present its next byte the following cycle.
REQ-008 gnt  output  NREQ  one-hot grant of the current burst; all-zero when idle.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 w_data  output  DBIT  byte to the UART transmit FIFO.
REQ-011 wr_uart  output  1  write strobe to the UART transmit FIFO.
REQ-012 tx_full  input  1  UART transmit FIFO full.

Function
REQ-013 FSM states SHALL be IDLE, HDR (present only with UART_ARB_HDR_EN), XFER.
REQ-014 Eligible requester SHALL be one with req[i]=1 and len slice nonzero; zero-length requests are ignored.
REQ-015 In IDLE, the arbiter SHALL pick the first eligible index searching round-robin from last_winner+1 modulo NREQ, latch its index and len into cnt, assert gnt next cycle, and enter HDR or XFER.
REQ-016 last_winner SHALL update to the granted index at burst end; after reset, index 0 has highest priority.
REQ-017 In HDR and XFER, wr_uart SHALL equal ~tx_full (combinational); no write SHALL occur while tx_full=1.
REQ-018 In XFER, each write SHALL drive w_data=din slice of the granted requester, pulse ack of that requester in the same cycle, and decrement cnt.
REQ-019 A write with cnt==1 SHALL end the burst: next state IDLE, gnt cleared next cycle.
REQ-020 Re-arbitration SHALL occur only in IDLE; changes to req or len during a burst SHALL be ignored.
REQ-021 Throughput: one byte per cycle while tx_full=0; burst of L bytes with no backpressure SHALL occupy L cycles in XFER plus one IDLE cycle between bursts.
REQ-022 ack SHALL never be asserted for a non-granted requester; at most one ack bit high per cycle.
REQ-023 w_data SHALL be 0 when wr_uart=0.

Reset
REQ-024 On reset_n=0 at a clock edge: state IDLE, gnt=0, ack=0, busy=0, wr_uart=0, cnt=0, last_winner=NREQ-1, regardless of any burst in progress; an aborted burst SHALL not resume.

Configuration
REQ-025 Macro UART_ARB_HDR_EN defined: after grant, the FSM SHALL enter HDR and write one header byte {1'b1, zero-padded granted index in DBIT-1 bits} before XFER; header write SHALL produce no ack.
REQ-026 UART_ARB_HDR_EN undefined: HDR state SHALL not exist; grant goes directly to XFER; no header byte SHALL be written.

Structure
REQ-027 A shared package SHALL hold the FSM state enum and the header marker constant (MSB=1).
REQ-028 One sub-module, rr_pick, SHALL implement the combinational round-robin selector (req mask, last_winner -> one-hot winner, valid).
REQ-029 The block SHALL connect to the uart module through w_data, wr_uart, tx_full only.

Verification
REQ-030 Single requester: req=4'b0010, len1=3, din1=0xA1,0xA2,0xA3, tx_full=0 -> gnt=0010 one cycle after req, three consecutive wr_uart with w_data A1,A2,A3, three ack[1] pulses, gnt=0 after.
REQ-031 Round-robin: req=4'b1111 held, all len=1 -> grant order 0,1,2,3,0 with exactly one IDLE cycle between bursts.
REQ-032 Backpressure: burst len=4, tx_full=1 for cycles 2-4 of XFER -> wr_uart and ack low during those cycles, all four bytes delivered in order, none duplicated.
REQ-033 Zero length and mid-burst changes: req0 with len0=0 and req2 len2=2 -> only requester 2 granted; deasserting req2 after first byte still delivers second byte.
REQ-034 Reset mid-burst: reset_n=0 during XFER with cnt=5 -> next cycle gnt=0, wr_uart=0, busy=0; after release, arbitration restarts with index 0 highest priority.
REQ-035 With UART_ARB_HDR_EN, DBIT=8: grant to requester 2, len=1 -> w_data 0x82 then data byte; ack only on the data byte.

Source files
------------

// File: rtl/uart_tx_arb_pkg.sv
// Shared types for the UART transmit arbiter.
// Optional header-byte feature is selected by the macro UART_ARB_HDR_EN.
package uart_tx_arb_pkg;

   // Arbiter FSM states; the header state only exists when the feature is built in.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
`ifdef UART_ARB_HDR_EN
      ST_HDR  = 2'd1,
`endif
      ST_XFER = 2'd2
   } arb_state_e;

   // MSB of the header byte; the lower bits carry the granted requester index.
   localparam logic HDR_MARK = 1'b1;

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin selector: starting one past last_i, returns the
// first set bit of mask_i as a one-hot vector plus its index.
module rr_pick #(
   parameter int NREQ = 4,
   parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] mask_i,
   input  logic [IW-1:0]   last_i,
   output logic [NREQ-1:0] win_o,
   output logic [IW-1:0]   win_idx_o,
   output logic            valid_o
);

   int pos_s;

   // Walk the requesters in rotating order and keep the first hit.
   always_comb begin
      win_o     = {NREQ{1'b0}};
      win_idx_o = {IW{1'b0}};
      valid_o   = 1'b0;
      pos_s     = 0;
      for (int k = 1; k <= NREQ; k++) begin
         pos_s = (int'(last_i) + k) % NREQ;
         if (!valid_o && mask_i[pos_s]) begin
            valid_o   = 1'b1;
            win_idx_o = IW'(pos_s);
            win_o     = {{(NREQ-1){1'b0}}, 1'b1} << pos_s;
         end else begin
            valid_o   = valid_o;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arb.sv
// Burst arbiter feeding a UART transmit FIFO from NREQ requesters.
// Define UART_ARB_HDR_EN to prefix every burst with a header byte
// {1'b1, granted index}; otherwise grants go straight to data transfer.
module uart_tx_arb
   import uart_tx_arb_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int DBIT = 8,
   parameter int LENW = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*LENW-1:0] len,
   input  logic [NREQ*DBIT-1:0] din,
   output logic [NREQ-1:0]      ack,
   output logic [NREQ-1:0]      gnt,
   output logic                 busy,
   output logic [DBIT-1:0]      w_data,
   output logic                 wr_uart,
   input  logic                 tx_full
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [LENW-1:0] CNT_ONE = {{(LENW-1){1'b0}}, 1'b1};

   arb_state_e      state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [IW-1:0]   last_q, last_d;
   logic [LENW-1:0] cnt_q, cnt_d;
   logic [NREQ-1:0] gnt_q, gnt_d;

   logic [NREQ-1:0] elig_s;
   logic [NREQ-1:0] win_s;
   logic [IW-1:0]   win_idx_s;
   logic            win_vld_s;
   logic [LENW-1:0] win_len_s;
   logic [DBIT-1:0] cur_byte_s;

   // A requester is only eligible with a nonzero burst length.
   always_comb begin
      elig_s = {NREQ{1'b0}};
      for (int i = 0; i < NREQ; i++) begin
         elig_s[i] = req[i] && (len[i*LENW +: LENW] != {LENW{1'b0}});
      end
   end

   rr_pick #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_rr_pick (
      .mask_i    (elig_s),
      .last_i    (last_q),
      .win_o     (win_s),
      .win_idx_o (win_idx_s),
      .valid_o   (win_vld_s)
   );

   assign win_len_s  = len[win_idx_s*LENW +: LENW];
   assign cur_byte_s = din[idx_q*DBIT +: DBIT];

   assign gnt  = gnt_q;
   assign busy = (state_q != ST_IDLE);

   // Next-state logic and the FIFO-side write/ack strobes.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      gnt_d   = gnt_q;
      wr_uart = 1'b0;
      w_data  = {DBIT{1'b0}};
      ack     = {NREQ{1'b0}};
      case (state_q)
         ST_IDLE: begin
            if (win_vld_s) begin
               idx_d = win_idx_s;
               cnt_d = win_len_s;
               gnt_d = win_s;
`ifdef UART_ARB_HDR_EN
               state_d = ST_HDR;
`else
               state_d = ST_XFER;
`endif
            end else begin
               gnt_d = {NREQ{1'b0}};
            end
         end
`ifdef UART_ARB_HDR_EN
         ST_HDR: begin
            wr_uart = ~tx_full;
            if (!tx_full) begin
               w_data  = {HDR_MARK, (DBIT-1)'(idx_q)};
               state_d = ST_XFER;
            end else begin
               w_data  = {DBIT{1'b0}};
            end
         end
`endif
         ST_XFER: begin
            wr_uart = ~tx_full;
            if (!tx_full) begin
               w_data = cur_byte_s;
               ack    = gnt_q;
               cnt_d  = cnt_q - CNT_ONE;
               if (cnt_q == CNT_ONE) begin
                  state_d = ST_IDLE;
                  gnt_d   = {NREQ{1'b0}};
                  last_d  = idx_q;
               end else begin
                  state_d = ST_XFER;
               end
            end else begin
               w_data = {DBIT{1'b0}};
            end
         end
         default: begin
            state_d = ST_IDLE;
            gnt_d   = {NREQ{1'b0}};
            cnt_d   = {LENW{1'b0}};
         end
      endcase
   end

   // State registers; reset abandons any burst and restores index-0 priority.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         idx_q   <= {IW{1'b0}};
         last_q  <= IW'(NREQ - 1);
         cnt_q   <= {LENW{1'b0}};
         gnt_q   <= {NREQ{1'b0}};
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
      end
   end

endmodule
